// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Contents:
//   SEG_0 .. SEG_9  segment patterns (bit0=a .. bit6=g, active-high)
//   SEG_BLANK       all segments off
//   DIGIT_BLANK     nibble stored for a blank digit
//   state_t         scan FSM state encodings
package seven_segment_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // no strobe, or several strobes at once
        ST_SETTLE = 2'd1,  // one strobe active, waiting for a stable window
        ST_HOLD   = 2'd2   // current pattern already committed
    } state_t;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational decode of a seven-segment pattern back to a BCD digit.
// Ports:
//   seg    in   7  segment pattern, bit0=a .. bit6=g
//   legal  out  1  pattern is one of the ten digit codes
//   blank  out  1  pattern is all segments off
//   digit  out  4  decoded digit; DIGIT_BLANK for blank or illegal patterns
module seven_segment_pattern_decoder
    import seven_segment_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] digit
);

    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        digit = DIGIT_BLANK;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Receive side of a multiplexed seven-segment display bus. Synchronises the
// segment lines and digit strobes, waits for each pattern to be stable, decodes
// it and assembles a frame of NUM_DIGITS digits handed out over valid/ready.
// Ports:
//   clk           in   1             rising-edge clock
//   rst_n         in   1             asynchronous active-low reset
//   seg_in        in   7             segments, active-high, asynchronous
//   an_in         in   NUM_DIGITS    digit strobes, active-high, asynchronous
//   frame_digits  out  4*NUM_DIGITS  digit i at [4i+3:4i], 4'hF = blank
//   frame_valid   out  1             frame_digits holds an unconsumed frame
//   frame_ready   in   1             consumer accepts when frame_valid is high
//   pat_err       out  1             pulse: committed pattern is illegal
//   strobe_err    out  1             pulse: strobes became multi-hot
//   overrun       out  1             pulse: unaccepted frame was overwritten
module seven_segment_scan_decoder
    import seven_segment_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    pat_err,
    output logic                    strobe_err,
    output logic                    overrun
);

    localparam int SW    = NUM_DIGITS + 7;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);

    // Synchroniser: sync2 is the sample the rest of the logic works on,
    // sync1 is the sample it will see next.
    logic [SW-1:0] sync1, sync2;
    logic [NUM_DIGITS-1:0] s_an, n_an;
    logic [6:0]            s_seg;

    assign s_an  = sync2[SW-1:7];
    assign s_seg = sync2[6:0];
    assign n_an  = sync1[SW-1:7];

    // Change is detected on the way into sync2, so the counter, the FSM
    // state and the sample in sync2 always describe the same sample. That is
    // what makes a clean change commit exactly STABLE_CYCLES+2 edges later.
    logic change_next;
    logic n_onehot, n_multi, s_multi;

    assign change_next = (sync1 != sync2);
    assign n_multi     = ((n_an & (n_an - AN_ONE)) != '0);
    assign n_onehot    = (n_an != '0) && !n_multi;
    assign s_multi     = ((s_an & (s_an - AN_ONE)) != '0);

    logic [CNT_W-1:0] cnt;
    state_t           state, state_next;
    logic             commit;

    logic       dec_legal, dec_blank;
    logic [3:0] dec_digit;

    seven_segment_pattern_decoder u_decoder (
        .seg   (s_seg),
        .legal (dec_legal),
        .blank (dec_blank),
        .digit (dec_digit)
    );

    logic [NUM_DIGITS-1:0][3:0] digit_reg, digit_next;
    logic [NUM_DIGITS-1:0]      seen, seen_next;
    logic                       commit_ok, frame_done;

    // Scan FSM: next state and the commit strobe.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            ST_IDLE:   state_next = ST_IDLE;
            ST_SETTLE: begin
                if (cnt == CNT_MAX) begin
                    commit     = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD:   state_next = ST_HOLD;
            default:   state_next = ST_IDLE;
        endcase
        // A new sample always restarts the scan of that sample.
        if (change_next) begin
            state_next = n_onehot ? ST_SETTLE : ST_IDLE;
        end
    end

    // Commit updates the working digit set; s_an is one-hot whenever commit
    // is high, so at most one digit is written.
    assign commit_ok = commit && (dec_legal || dec_blank);

    always_comb begin
        digit_next = digit_reg;
        seen_next  = seen;
        if (commit_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_an[i]) begin
                    digit_next[i] = dec_digit;
                    seen_next[i]  = 1'b1;
                end
            end
        end
    end

    assign frame_done = commit_ok && (&seen_next);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            cnt        <= '0;
            state      <= ST_IDLE;
            pat_err    <= 1'b0;
            strobe_err <= 1'b0;
        end else begin
            sync1 <= {an_in, seg_in};
            sync2 <= sync1;
            if (change_next) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end
            state      <= state_next;
            pat_err    <= commit && !dec_legal && !dec_blank;
            // Only the transition into multi-hot reports, not its duration.
            strobe_err <= change_next && n_multi && !s_multi;
        end
    end

    // NOTE: digit_reg is a handful of flops and reset clears a partial
    // frame, so it is reset along with the rest rather than left as memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_reg    <= '0;
            seen         <= '0;
            frame_digits <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            digit_reg <= digit_next;
            seen      <= frame_done ? '0 : seen_next;
            if (frame_done) begin
                // Completion wins over a same-cycle accept: the new frame
                // loads and valid stays high.
                frame_digits <= digit_next;
                frame_valid  <= 1'b1;
                overrun      <= frame_valid && !frame_ready;
            end else begin
                overrun <= 1'b0;
                if (frame_valid && frame_ready) begin
                    frame_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed self-checking bench for seven_segment_scan_decoder
// (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seven_segment_scan_decoder;
    import seven_segment_scan_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h00;
    logic [3:0]  an_in = 4'h0;
    logic [15:0] frame_digits;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic        pat_err, strobe_err, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse / valid-cycle counters sampled on the falling edge.
    int pat_cnt = 0, strobe_cnt = 0, ovr_cnt = 0, valid_cnt = 0;
    int base_valid;

    always #5 clk = ~clk;

    seven_segment_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_in       (seg_in),
        .an_in        (an_in),
        .frame_digits (frame_digits),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .pat_err      (pat_err),
        .strobe_err   (strobe_err),
        .overrun      (overrun)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            pat_cnt    += int'(pat_err);
            strobe_cnt += int'(strobe_err);
            ovr_cnt    += int'(overrun);
            valid_cnt  += int'(frame_valid);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern and dwell for n edges; returns 1 time unit after an edge.
    task automatic step(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Final digit of a frame with frame_ready high: commit lands on the
    // sixth edge after the change, valid is high for exactly one cycle.
    task automatic last_digit(input string tag, input logic [3:0] an,
                              input logic [6:0] seg, input logic [15:0] exp_frame);
        step(an, seg, 5);
        check({tag, "_valid_before"}, 32'(frame_valid), 32'd0);
        step(an, seg, 1);
        check({tag, "_valid_at"}, 32'(frame_valid), 32'd1);
        check({tag, "_digits"}, 32'(frame_digits), 32'(exp_frame));
        step(an, seg, 1);
        check({tag, "_valid_after"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(frame_digits), 32'h0);
        check("rst_valid",  32'(frame_valid),  32'h0);
        check("rst_errs",   32'({pat_err, strobe_err, overrun}), 32'h0);
        rst_n = 1'b1;
        step(4'b0000, 7'h00, 2);

        // Basic scan 1,2,3,4
        step(4'b0001, SEG_1, 8);
        step(4'b0010, SEG_2, 8);
        step(4'b0100, SEG_3, 8);
        last_digit("scan", 4'b1000, SEG_4, 16'h4321);
        check("scan_valid_cycles", 32'(valid_cnt), 32'd1);
        check("scan_errs", 32'(pat_cnt + strobe_cnt + ovr_cnt), 32'd0);

        // Glitch: 2-cycle 8 inside a 2 dwell on the last digit of the frame
        step(4'b0001, SEG_1, 8);
        step(4'b0100, SEG_3, 8);
        step(4'b1000, SEG_4, 8);
        step(4'b0010, SEG_2, 3);
        step(4'b0010, SEG_8, 2);
        last_digit("glitch", 4'b0010, SEG_2, 16'h4321);

        // Illegal pattern on digit 0, then the legal 0
        step(4'b0001, 7'h49, 8);
        check("illegal_pat_err", 32'(pat_cnt), 32'd1);
        base_valid = valid_cnt;
        step(4'b0010, SEG_2, 8);
        step(4'b0100, SEG_3, 8);
        step(4'b1000, SEG_4, 8);
        check("illegal_no_frame", 32'(valid_cnt - base_valid), 32'd0);
        last_digit("illegal_recover", 4'b0001, SEG_0, 16'h4320);

        // Multi-hot strobe, then a blank digit
        step(4'b0011, SEG_1, 10);
        check("strobe_err_once", 32'(strobe_cnt), 32'd1);
        check("strobe_fsm_idle", 32'(dut.state), 32'(ST_IDLE));
        base_valid = valid_cnt;
        step(4'b0100, SEG_BLANK, 8);
        step(4'b0010, SEG_2, 8);
        step(4'b1000, SEG_4, 8);
        check("strobe_no_frame", 32'(valid_cnt - base_valid), 32'd0);
        last_digit("blank", 4'b0001, SEG_1, 16'h4F21);
        check("mid_pat_err", 32'(pat_cnt), 32'd1);

        // Back-pressure: two frames while not ready, then same-cycle accept
        frame_ready = 1'b0;
        step(4'b0010, SEG_3, 8);
        step(4'b0100, SEG_4, 8);
        step(4'b1000, SEG_5, 8);
        step(4'b0001, SEG_6, 8);
        check("bp_frame_a_valid",  32'(frame_valid),  32'd1);
        check("bp_frame_a_digits", 32'(frame_digits), 32'h5436);
        step(4'b0010, SEG_7, 8);
        step(4'b0100, SEG_8, 8);
        step(4'b1000, SEG_9, 8);
        check("bp_a_stable", 32'(frame_digits), 32'h5436);
        step(4'b0001, SEG_0, 6);
        check("bp_overrun_pulse",  32'(overrun),      32'd1);
        check("bp_frame_b_valid",  32'(frame_valid),  32'd1);
        check("bp_frame_b_digits", 32'(frame_digits), 32'h9870);
        step(4'b0001, SEG_0, 2);
        check("bp_overrun_count", 32'(ovr_cnt), 32'd1);
        step(4'b0010, SEG_1, 8);
        step(4'b0100, SEG_2, 8);
        step(4'b1000, SEG_3, 8);
        check("bp_b_stable", 32'(frame_digits), 32'h9870);
        step(4'b0001, SEG_4, 5);
        frame_ready = 1'b1;
        step(4'b0001, SEG_4, 1);
        check("same_cycle_valid",   32'(frame_valid),  32'd1);
        check("same_cycle_digits",  32'(frame_digits), 32'h3214);
        check("same_cycle_no_ovr",  32'(overrun),      32'd0);
        step(4'b0001, SEG_4, 1);
        check("same_cycle_accepted", 32'(frame_valid), 32'd0);

        // Reset mid-frame discards the partial digits
        step(4'b0010, SEG_2, 8);
        step(4'b0100, SEG_3, 8);
        step(4'b1000, SEG_4, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_digits", 32'(frame_digits), 32'h0);
        check("midrst_valid",  32'(frame_valid),  32'h0);
        check("midrst_errs",   32'({pat_err, strobe_err, overrun}), 32'h0);
        step(4'b1000, SEG_4, 3);
        rst_n = 1'b1;
        base_valid = valid_cnt;
        step(4'b1000, SEG_4, 8);
        step(4'b0001, SEG_1, 8);
        check("midrst_partial_discarded", 32'(valid_cnt - base_valid), 32'd0);
        step(4'b0010, SEG_2, 8);
        last_digit("midrst_frame", 4'b0100, SEG_3, 16'h4321);
        check("final_strobe_count", 32'(strobe_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
